// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: shared prescaler + period counter driving N duty channels.
// Period and duty are double-buffered and only change at a period boundary.
//
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   en          : run enable (low holds counters at 0, outputs idle)
//   prescale    : one tick every prescale+1 clk cycles
//   period      : requested period in ticks, loaded at boundary
//   inc, dec    : per-channel duty step requests (rising-edge)
//   pwm_out     : registered PWM outputs
//   duty_flat   : active duty per channel, ch i at [i*WIDTH +: WIDTH]
//   period_end  : one-clk pulse per period boundary
module pwm_multi_ch #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 8,
  parameter int PRESC_W        = 19,
  parameter int DEFAULT_PERIOD = 100,
  parameter int ACTIVE_LOW     = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [PRESC_W-1:0]        prescale,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       dec,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS*WIDTH-1:0] duty_flat,
  output logic                      period_end
);

  localparam logic [WIDTH-1:0] DEF_P =
    WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] W_ONE = 1;
  localparam logic [WIDTH-1:0] W_TWO = 2;
  localparam logic [PRESC_W-1:0] P_ONE = 1;
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);
  localparam logic [CHANNELS-1:0] IDLE =
    {CHANNELS{IDLE_LVL}};

  logic [PRESC_W-1:0] pre_cnt;
  logic [WIDTH-1:0]   cntr;
  logic [WIDTH-1:0]   period_active;
  logic [WIDTH-1:0]   last_cnt;
  logic [WIDTH-1:0]   duty_req    [CHANNELS];
  logic [WIDTH-1:0]   duty_active [CHANNELS];
  logic [CHANNELS-1:0] inc_q, dec_q;
  logic [CHANNELS-1:0] ri, rd;
  logic [CHANNELS-1:0] pwm_nxt;
  logic tick;
  logic at_last;
  logic boundary;

  assign tick = en && (pre_cnt >= prescale);

  // Guarded so period_active-1 never wraps; 0 and 1 both
  // end the period on every tick.
  assign last_cnt = (period_active >= W_TWO)
                  ? period_active - W_ONE : '0;
  assign at_last  = (period_active <= W_ONE) ||
                    (cntr >= last_cnt);
  assign boundary = tick && at_last;

  assign ri = inc & ~inc_q;
  assign rd = dec & ~dec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (!en || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + P_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntr          <= '0;
      period_active <= DEF_P;
      period_end    <= 1'b0;
    end else begin
      period_end <= boundary;
      if (!en) begin
        cntr <= '0;
      end else if (boundary) begin
        cntr          <= '0;
        period_active <= period;
      end else if (tick) begin
        cntr <= cntr + W_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q <= '0;
      dec_q <= '0;
    end else begin
      inc_q <= inc;
      dec_q <= dec;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_req[i] <= '0;
      end else begin
        unique case ({ri[i], rd[i]})
          2'b10: begin
            if (duty_req[i] < period)
              duty_req[i] <= duty_req[i] + W_ONE;
          end
          2'b01: begin
            if (duty_req[i] != '0)
              duty_req[i] <= duty_req[i] - W_ONE;
          end
          default: ;
        endcase
      end
    end

    // Clamp to the incoming period so a shortened period
    // never leaves a duty above it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_active[i] <= '0;
      end else if (boundary) begin
        duty_active[i] <= (duty_req[i] < period)
                        ? duty_req[i] : period;
      end
    end

    assign duty_flat[i*WIDTH +: WIDTH] = duty_active[i];

    always_comb begin
      pwm_nxt[i] = (en && (cntr < duty_active[i])) ^ IDLE_LVL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= IDLE;
    end else begin
      pwm_out <= pwm_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: directed + random stimulus vs behavioural model.
// Two DUTs share inputs: ACTIVE_LOW=0 and ACTIVE_LOW=1.
module tb_pwm_multi_ch;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int PW = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  period = '0;
  logic [CH-1:0] inc = '0;
  logic [CH-1:0] dec = '0;

  logic [CH-1:0]   pwm_out, pwm_out_al;
  logic [CH*W-1:0] duty_flat, duty_flat_al;
  logic            period_end, period_end_al;

  always #5 clk = ~clk;

  pwm_multi_ch #(.ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .prescale(prescale), .period(period),
    .inc(inc), .dec(dec),
    .pwm_out(pwm_out), .duty_flat(duty_flat),
    .period_end(period_end)
  );

  pwm_multi_ch #(.ACTIVE_LOW(1)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .en(en),
    .prescale(prescale), .period(period),
    .inc(inc), .dec(dec),
    .pwm_out(pwm_out_al), .duty_flat(duty_flat_al),
    .period_end(period_end_al)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Behavioural model: counts ticks within a period of
  // length max(period_active,1); outputs are what the
  // registered pins show after each clock.
  int m_pre, m_cnt, m_pact;
  int m_req [CH];
  int m_act [CH];
  logic [CH-1:0] m_incq, m_decq, m_pwm;
  logic m_pend;

  task automatic model_reset();
    m_pre = 0; m_cnt = 0; m_pact = 100;
    for (int i = 0; i < CH; i++) begin
      m_req[i] = 0; m_act[i] = 0;
    end
    m_incq = '0; m_decq = '0; m_pwm = '0; m_pend = 1'b0;
  endtask

  task automatic model_step();
    int  p_in, ps, plen;
    bit  tk, bnd, up, dn;
    p_in = int'(period);
    ps   = int'(prescale);
    tk   = en && (m_pre >= ps);
    plen = (m_pact < 1) ? 1 : m_pact;
    bnd  = tk && (m_cnt + 1 >= plen);
    for (int i = 0; i < CH; i++)
      m_pwm[i] = en && (m_cnt < m_act[i]);
    for (int i = 0; i < CH; i++) begin
      if (bnd)
        m_act[i] = (m_req[i] < p_in) ? m_req[i] : p_in;
      up = inc[i] && !m_incq[i];
      dn = dec[i] && !m_decq[i];
      if (up && !dn && m_req[i] < p_in) m_req[i]++;
      if (dn && !up && m_req[i] > 0)    m_req[i]--;
    end
    m_incq = inc;
    m_decq = dec;
    m_pend = bnd;
    if (!en) begin
      m_pre = 0; m_cnt = 0;
    end else begin
      m_pre = tk ? 0 : m_pre + 1;
      m_cnt = bnd ? 0 : (tk ? m_cnt + 1 : m_cnt);
    end
    if (bnd) m_pact = p_in;
  endtask

  task automatic compare();
    logic [CH*W-1:0] ef;
    logic [CH-1:0]   inv;
    for (int i = 0; i < CH; i++)
      ef[i*W +: W] = W'(m_act[i]);
    inv = ~m_pwm;
    check("pwm", 64'(pwm_out), 64'(m_pwm));
    check("pwm_al", 64'(pwm_out_al), 64'(inv));
    check("duty", 64'(duty_flat), 64'(ef));
    check("duty_al", 64'(duty_flat_al), 64'(ef));
    check("pend", 64'(period_end), 64'(m_pend));
    check("pend_al", 64'(period_end_al), 64'(m_pend));
  endtask

  task automatic clk_step();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_bnd(input string tag);
    int k;
    k = 0;
    do begin
      clk_step();
      k++;
    end while (!period_end && k < 300);
    check(tag, 64'(k < 300), 64'd1);
  endtask

  task automatic pulse(input logic [CH-1:0] pi,
                       input logic [CH-1:0] pd,
                       input int n);
    repeat (n) begin
      inc = pi; dec = pd;
      clk_step();
      inc = '0; dec = '0;
      clk_step();
    end
  endtask

  task automatic count_hi(input int ch, input int n,
                          output int hi, output int ends);
    hi = 0; ends = 0;
    repeat (n) begin
      clk_step();
      hi   += int'(pwm_out[ch]);
      ends += int'(period_end);
    end
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare();
    check("rst_pwm_al", 64'(pwm_out_al), 64'hF);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int hi, ends;
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    rst_n = 1'b1;

    // Three inc pulses on ch0, 10-tick period
    en = 1'b1; prescale = '0; period = 8'd10;
    clk_step();
    pulse(4'b0001, 4'b0000, 3);
    wait_bnd("t1_bnd");
    check("t1_duty", 64'(duty_flat[7:0]), 64'd3);
    count_hi(0, 10, hi, ends);
    check("t1_hi", 64'(hi), 64'd3);
    check("t1_ends", 64'(ends), 64'd1);

    // Saturation on ch2 with period 5
    period = 8'd5;
    inc = 4'b0100;
    repeat (20) clk_step();
    inc = '0;
    wait_bnd("t3_bnd0");
    check("t3_hold", 64'(duty_flat[23:16]), 64'd1);
    pulse(4'b0100, 4'b0000, 7);
    wait_bnd("t3_bnd1");
    check("t3_sat", 64'(duty_flat[23:16]), 64'd5);
    count_hi(2, 5, hi, ends);
    check("t3_full", 64'(hi), 64'd5);
    pulse(4'b0000, 4'b0100, 1);
    wait_bnd("t3_bnd2");
    check("t3_dec", 64'(duty_flat[23:16]), 64'd4);
    pulse(4'b0000, 4'b0100, 8);
    wait_bnd("t3_bnd3");
    check("t3_zero", 64'(duty_flat[23:16]), 64'd0);
    count_hi(2, 5, hi, ends);
    check("t3_idle", 64'(hi), 64'd0);
    pulse(4'b0100, 4'b0100, 1);
    wait_bnd("t3_bnd4");
    check("t3_both", 64'(duty_flat[23:16]), 64'd0);

    // Mid-period async reset, then en=0 with duty edits
    repeat (3) clk_step();
    async_reset();
    en = 1'b0;
    pulse(4'b1000, 4'b0000, 2);
    check("en0_al", 64'(pwm_out_al), 64'hF);
    en = 1'b1;

    // Random phase
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 99) == 0)
        prescale = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0)
        period = W'($urandom_range(0, 14));
      inc = CH'($urandom & $urandom);
      dec = CH'($urandom & $urandom & $urandom);
      clk_step();
      if (n == 2000 || $urandom_range(0, 799) == 0)
        async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
